imem_loader: RTL and testbench

Byte-serial program loader that writes 16-bit instruction words into the CPU instruction memory, the write-side counterpart of the IF-stage fetch path (`IMemory[PC>>1]`). It holds the CPU in reset while a framed program image arrives over a valid/ready byte stream. It writes each assembled word to consecutive word addresses starting at 0, verifies a trailing XOR checksum, and releases the CPU only on a clean load.

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader for the CPU instruction memory.
// Receives a framed image (16-bit big-endian word count, N words sent high
// byte first, then an XOR checksum of the payload bytes). It writes each word
// to consecutive addresses starting at 0. The CPU is held in reset until a
// load completes with a matching checksum.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE, ERR
  } state_t;

  // Largest legal word count, widened so a 16-bit count compares without truncation.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state_q,  state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [ADDR_W:0]   nwords_q, nwords_d;
  logic [ADDR_W:0]   wcnt_q,   wcnt_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [15:0]       wdata_q,  wdata_d;
  logic              we_q,     we_d;
  logic [7:0]        xor_q,    xor_d;

  logic              xfer;
  logic [15:0]       n_full;

  // Moore outputs decoded from the current state and the write registers.
  always_comb begin
    in_ready  = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == DAT_HI) ||
                (state_q == DAT_LO) || (state_q == CHK);
    cpu_hold  = (state_q != DONE);
    done      = (state_q == DONE);
    error     = (state_q == ERR);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  // Next-state logic: frame parsing, word assembly, address sequencing and the running XOR.
  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    xor_d    = xor_q;
    xfer     = in_valid && in_ready;
    n_full   = {cnt_hi_q, in_data};

    // Advance the address once the write strobe has been presented; saturate
    // rather than wrap so a full-depth image never aliases back onto word 0.
    if (we_q && (addr_q != '1)) begin
      addr_d = addr_q + 1'b1;
    end

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = CNT_HI;
          addr_d  = '0;
          wcnt_d  = '0;
          xor_d   = '0;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          cnt_hi_d = in_data;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (xfer) begin
          nwords_d = n_full[ADDR_W:0];
          if ((n_full != 16'd0) && ({1'b0, n_full} <= DEPTH_L)) begin
            state_d = DAT_HI;
          end else begin
            state_d = ERR;
          end
        end
      end
      DAT_HI: begin
        if (xfer) begin
          wdata_d[15:8] = in_data;
          xor_d         = xor_q ^ in_data;
          state_d       = DAT_LO;
        end
      end
      DAT_LO: begin
        if (xfer) begin
          wdata_d[7:0] = in_data;
          xor_d        = xor_q ^ in_data;
          we_d         = 1'b1;
          wcnt_d       = wcnt_q + 1'b1;
          state_d      = (wcnt_d < nwords_q) ? DAT_HI : CHK;
        end
      end
      CHK: begin
        if (xfer) begin
          state_d = (in_data == xor_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any load, including a pending write strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_hi_q <= '0;
      nwords_q <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      xor_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      nwords_q <= nwords_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      xor_q    <= xor_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_imem_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [15:0]       wr_data_q[$];
  logic [7:0]        frame[$];
  logic [15:0]       exp_words[$];
  bit                stall_en = 1'b0;
  bit                m_done, m_err;

  typedef struct {
    string       name;
    int          len;
    logic [79:0] bytes;   // first byte in bits [79:72]
    bit          exp_done;
    bit          exp_err;
    int          nwr;
    logic [31:0] words;   // first word in bits [31:16]
  } vec_t;
  vec_t vecs[6];

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // Log every write strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (stall_en) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake: in_ready stuck at 0, byte %0h", b);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Frame-level reference: decode count, words and checksum straight from the byte list.
  function automatic void model();
    int          n;
    logic [7:0]  x;
    exp_words.delete();
    n = int'({frame[0], frame[1]});
    m_done = 1'b0;
    m_err  = 1'b0;
    if (n == 0 || n > DEPTH) begin
      m_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_words.push_back({frame[2 + 2 * i], frame[3 + 2 * i]});
      x = x ^ frame[2 + 2 * i] ^ frame[3 + 2 * i];
    end
    if (frame[2 + 2 * n] == x) m_done = 1'b1;
    else                       m_err  = 1'b1;
  endfunction

  task automatic run_frame(input string name, input bit exp_done, input bit exp_err);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    check({name, " start done"},     32'(done),     32'd0);
    check({name, " start error"},    32'(error),    32'd0);
    check({name, " start cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({name, " start in_ready"}, 32'(in_ready), 32'd1);
    foreach (frame[i]) send_byte(frame[i]);
    check({name, " done"},     32'(done),     32'(exp_done));
    check({name, " error"},    32'(error),    32'(exp_err));
    check({name, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({name, " in_ready"}, 32'(in_ready), 32'd0);
    tick();
    check({name, " nwrites"}, 32'(wr_data_q.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++) begin
      if (i < wr_data_q.size()) begin
        check({name, " addr"}, 32'(wr_addr_q[i]), 32'(i));
        check({name, " data"}, 32'(wr_data_q[i]), 32'(exp_words[i]));
      end
    end
  endtask

  function automatic void set_vec(input int i, input string nm, input int len,
                                  input logic [79:0] b, input bit d, input bit e,
                                  input int nwr, input logic [31:0] w);
    vecs[i].name     = nm;
    vecs[i].len      = len;
    vecs[i].bytes    = b;
    vecs[i].exp_done = d;
    vecs[i].exp_err  = e;
    vecs[i].nwr      = nwr;
    vecs[i].words    = w;
  endfunction

  function automatic void load_hazard();
    logic [15:0] prog [8];
    logic [7:0]  x;
    prog = '{16'h410F, 16'h4207, 16'h26C0, 16'h1780, 16'h3B80, 16'h0BC0, 16'h7E40, 16'h7B40};
    frame.delete();
    frame.push_back(8'h00);
    frame.push_back(8'h08);
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      frame.push_back(prog[i][15:8]);
      frame.push_back(prog[i][7:0]);
      x = x ^ prog[i][15:8] ^ prog[i][7:0];
    end
    frame.push_back(x);
  endfunction

  initial begin
    set_vec(0, "clean2",   7, {56'h00_02_41_0F_42_07_0B, 24'h0}, 1, 0, 2, 32'h410F_4207);
    set_vec(1, "reload1",  5, {40'h00_01_12_34_26, 40'h0},       1, 0, 1, 32'h1234_0000);
    set_vec(2, "badchk",   7, {56'h00_02_41_0F_42_07_0C, 24'h0}, 0, 1, 2, 32'h410F_4207);
    set_vec(3, "cnt0",     2, {16'h00_00, 64'h0},                0, 1, 0, 32'h0);
    set_vec(4, "cnt1025",  2, {16'h04_01, 64'h0},                0, 1, 0, 32'h0);
    set_vec(5, "fromerr",  7, {56'h00_02_41_0F_42_07_0B, 24'h0}, 1, 0, 2, 32'h410F_4207);

    // Reset state
    #12;
    check("rst cpu_hold",  32'(cpu_hold),  32'd1);
    check("rst in_ready",  32'(in_ready),  32'd0);
    check("rst mem_we",    32'(mem_we),    32'd0);
    check("rst done",      32'(done),      32'd0);
    check("rst error",     32'(error),     32'd0);
    check("rst mem_addr",  32'(mem_addr),  32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    check("idle in_ready", 32'(in_ready), 32'd0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      frame.delete();
      exp_words.delete();
      for (int j = 0; j < vecs[v].len; j++) frame.push_back(vecs[v].bytes[79 - 8 * j -: 8]);
      for (int j = 0; j < vecs[v].nwr; j++) exp_words.push_back(vecs[v].words[31 - 16 * j -: 16]);
      run_frame(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Start is ignored while a load is in progress
    frame = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h00);
    pulse_start();
    check("midstart error", 32'(error), 32'd0);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h66);
    check("midstart done", 32'(done), 32'd1);
    tick();
    check("midstart nwr", 32'(wr_data_q.size()), 32'd1);

    // Stalled 8-word hazard program
    load_hazard();
    model();
    stall_en = 1'b1;
    run_frame("hazard8", m_done, m_err);
    stall_en = 1'b0;

    // Reset asserted right after the 3rd word's low-byte transfer
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h41); send_byte(8'h0F);
    send_byte(8'h42); send_byte(8'h07);
    send_byte(8'h26); send_byte(8'hC0);
    reset_n = 1'b0;
    #1;
    check("midrst mem_we",    32'(mem_we),    32'd0);
    check("midrst cpu_hold",  32'(cpu_hold),  32'd1);
    check("midrst in_ready",  32'(in_ready),  32'd0);
    check("midrst done",      32'(done),      32'd0);
    check("midrst error",     32'(error),     32'd0);
    check("midrst mem_addr",  32'(mem_addr),  32'd0);
    check("midrst mem_wdata", 32'(mem_wdata), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst nwrites", 32'(wr_data_q.size()), 32'd2);
    frame = '{8'h00, 8'h02, 8'h41, 8'h0F, 8'h42, 8'h07, 8'h0B};
    model();
    run_frame("postrst", m_done, m_err);

    // Randomized frames against the model
    for (int r = 0; r < 12; r++) begin
      int          n;
      logic [7:0]  x;
      n = $urandom_range(1, 12);
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        frame.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      frame.push_back(x);
      model();
      stall_en = ($urandom_range(0, 1) == 1);
      run_frame("random", m_done, m_err);
    end
    stall_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
